// File: rtl/cfg_arbiter.sv
// Two-requester round-robin front end for the APB configuration bridge.
// Serialises register transfers from the host and the reload sequencer onto one M-side port.
module cfg_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 7,
   parameter int unsigned COEFF_WIDTH = 20,
   parameter int unsigned PDATA_WIDTH = 32,
   parameter int unsigned COMP        = 4,
   parameter int unsigned XFER_CYCLES = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req0,
   input  logic                          req1,
   input  logic                          wr0,
   input  logic                          wr1,
   input  logic [COMP-1:0]               sel0,
   input  logic [COMP-1:0]               sel1,
   input  logic [ADDR_WIDTH-1:0]         addr0,
   input  logic [ADDR_WIDTH-1:0]         addr1,
   input  logic signed [COEFF_WIDTH-1:0] wdata0,
   input  logic signed [COEFF_WIDTH-1:0] wdata1,
   output logic                          ack0,
   output logic                          ack1,
   output logic [PDATA_WIDTH-1:0]        rdata0,
   output logic [PDATA_WIDTH-1:0]        rdata1,
   output logic                          MTRANS,
   output logic                          MWRITE,
   output logic [COMP-1:0]               MSELx,
   output logic [ADDR_WIDTH-1:0]         MADDR,
   output logic [COEFF_WIDTH-1:0]        MWDATA,
   input  logic [PDATA_WIDTH-1:0]        MRDATA,
   output logic                          busy
);

   localparam int unsigned CNT_WIDTH = $clog2(XFER_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(XFER_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   wait_cnt;
   logic                   last_gnt;
   logic                   gnt;
   logic                   null_hold;

   logic                   pick1;
   logic                   win_wr;
   logic [COMP-1:0]        win_sel;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [COEFF_WIDTH-1:0] win_wdata;

   // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
   always_comb begin
      pick1     = req1 && (!req0 || !last_gnt);
      win_wr    = pick1 ? wr1 : wr0;
      win_sel   = pick1 ? sel1 : sel0;
      win_addr  = pick1 ? addr1 : addr0;
      win_wdata = pick1 ? COEFF_WIDTH'(wdata1) : COEFF_WIDTH'(wdata0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         last_gnt  <= 1'b1;
         gnt       <= 1'b0;
         null_hold <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         MTRANS    <= 1'b0;
         MWRITE    <= 1'b0;
         MSELx     <= '0;
         MADDR     <= '0;
         MWDATA    <= '0;
         busy      <= 1'b0;
      end else begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         MTRANS <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt      <= pick1;
                  last_gnt <= pick1;
                  busy     <= 1'b1;
                  // A null select skips the bridge; DONE is held one extra cycle so ack timing is fixed.
                  if (win_sel == '0) begin
                     state     <= DONE;
                     null_hold <= 1'b1;
                  end else begin
                     state  <= ISSUE;
                     MTRANS <= 1'b1;
                     MWRITE <= win_wr;
                     MSELx  <= win_sel;
                     MADDR  <= win_addr;
                     MWDATA <= win_wdata;
                  end
               end
            end
            ISSUE: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (wait_cnt == CNT_LAST) begin
                  state <= DONE;
                  MSELx <= '0;
                  ack0  <= !gnt;
                  ack1  <= gnt;
                  if (!MWRITE) begin
                     if (gnt) rdata1 <= MRDATA;
                     else     rdata0 <= MRDATA;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CNT_WIDTH'(1);
               end
            end
            DONE: begin
               if (null_hold) begin
                  null_hold <= 1'b0;
                  ack0      <= !gnt;
                  ack1      <= gnt;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_arbiter.sv
// Bench for cfg_arbiter: directed scenarios plus a randomized two-requester run
// checked against a fixed-service-time timeline model of the arbiter.
module tb_cfg_arbiter;

   localparam int unsigned AW   = 7;
   localparam int unsigned CW   = 20;
   localparam int unsigned PW   = 32;
   localparam int unsigned NS   = 4;
   localparam int unsigned XFER = 3;
   localparam int RN = 400;
   localparam int RL = RN + 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, wr0, wr1;
   logic [NS-1:0] sel0, sel1;
   logic [AW-1:0] addr0, addr1;
   logic [CW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [PW-1:0] rdata0, rdata1;
   logic          MTRANS, MWRITE;
   logic [NS-1:0] MSELx;
   logic [AW-1:0] MADDR;
   logic [CW-1:0] MWDATA;
   logic [PW-1:0] MRDATA;
   logic          busy;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   int            mt_cyc[$];
   logic          mt_wr[$];
   logic [NS-1:0] mt_sel[$];
   logic [AW-1:0] mt_addr[$];
   logic [CW-1:0] mt_data[$];
   int            ack_cyc[$];
   int            ack_who[$];

   cfg_arbiter #(
      .ADDR_WIDTH(AW), .COEFF_WIDTH(CW), .PDATA_WIDTH(PW), .COMP(NS), .XFER_CYCLES(XFER)
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .sel0(sel0), .sel1(sel1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR),
      .MWDATA(MWDATA), .MRDATA(MRDATA), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      sel0 = '0; sel1 = '0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; MRDATA = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic clear_obs;
      mt_cyc.delete(); mt_wr.delete(); mt_sel.delete(); mt_addr.delete(); mt_data.delete();
      ack_cyc.delete(); ack_who.delete();
   endtask

   // Steps n cycles, logging M-side starts and acks; a requester drops req the cycle after its ack.
   task automatic run_obs(input int n, input bit rearm);
      bit d0 = 0, d1 = 0, r0 = 0, r1 = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (d0) begin req0 = 1'b0; d0 = 0; r0 = rearm; end
         if (d1) begin req1 = 1'b0; d1 = 0; r1 = rearm; end
         @(negedge clk);
         if (MTRANS === 1'b1) begin
            mt_cyc.push_back(cyc); mt_wr.push_back(MWRITE); mt_sel.push_back(MSELx);
            mt_addr.push_back(MADDR); mt_data.push_back(MWDATA);
         end
         if (ack0 === 1'b1) begin ack_cyc.push_back(cyc); ack_who.push_back(0); d0 = 1; end
         if (ack1 === 1'b1) begin ack_cyc.push_back(cyc); ack_who.push_back(1); d1 = 1; end
         #1;
         if (r0) begin req0 = 1'b1; r0 = 0; end
         if (r1) begin req1 = 1'b1; r1 = 0; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b1; wr1 = 1'b0;
      sel0 = 4'b0011; sel1 = 4'b1000; addr0 = 7'h7F; addr1 = 7'h15;
      wdata0 = 20'hFFFFF; wdata1 = 20'h0F0F0; MRDATA = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (MTRANS !== 1'b0) begin errors++; $display("FAIL reset_mtrans: got %b expected 0", MTRANS); end
      checks++; if (MWRITE !== 1'b0) begin errors++; $display("FAIL reset_mwrite: got %b expected 0", MWRITE); end
      checks++; if (MSELx !== 4'h0) begin errors++; $display("FAIL reset_msel: got %h expected 0", MSELx); end
      checks++; if (MADDR !== 7'h0) begin errors++; $display("FAIL reset_maddr: got %h expected 0", MADDR); end
      checks++; if (MWDATA !== 20'h0) begin errors++; $display("FAIL reset_mwdata: got %h expected 0", MWDATA); end
      checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", {ack0, ack1}); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
      checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      do_reset();
   endtask

   task automatic test_single_write;
      int k;
      do_reset(); clear_obs();
      req0 = 1'b1; wr0 = 1'b1; sel0 = 4'b0001; addr0 = 7'h05; wdata0 = 20'h12345;
      k = cyc + 1;
      run_obs(12, 0);
      checks++; if (mt_cyc.size() !== 1) begin errors++; $display("FAIL wr_mtrans_count: got %0d expected 1", mt_cyc.size()); end
      checks++; if ((mt_cyc.size() > 0 ? mt_cyc[0] : -1) !== k) begin errors++; $display("FAIL wr_mtrans_cycle: got %0d expected %0d", (mt_cyc.size() > 0 ? mt_cyc[0] : -1), k); end
      checks++; if ((mt_cyc.size() > 0 ? {mt_wr[0], mt_sel[0], mt_addr[0], mt_data[0]} : 32'hX) !== {1'b1, 4'b0001, 7'h05, 20'h12345})
         begin errors++; $display("FAIL wr_mside_fields: got %h expected %h", (mt_cyc.size() > 0 ? {mt_wr[0], mt_sel[0], mt_addr[0], mt_data[0]} : 32'hX), {1'b1, 4'b0001, 7'h05, 20'h12345}); end
      checks++; if (ack_cyc.size() !== 1) begin errors++; $display("FAIL wr_ack_count: got %0d expected 1", ack_cyc.size()); end
      checks++; if ((ack_cyc.size() > 0 ? ack_cyc[0] : -1) !== k + int'(XFER) + 1) begin errors++; $display("FAIL wr_ack_cycle: got %0d expected %0d", (ack_cyc.size() > 0 ? ack_cyc[0] : -1), k + int'(XFER) + 1); end
      checks++; if ((ack_who.size() > 0 ? ack_who[0] : -1) !== 0) begin errors++; $display("FAIL wr_ack_owner: got %0d expected 0", (ack_who.size() > 0 ? ack_who[0] : -1)); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL wr_rdata0_kept: got %h expected 0", rdata0); end
      checks++; if ({MSELx, MADDR, MWRITE} !== {4'h0, 7'h05, 1'b1}) begin errors++; $display("FAIL wr_idle_hold: got %h expected %h", {MSELx, MADDR, MWRITE}, {4'h0, 7'h05, 1'b1}); end
   endtask

   task automatic test_read;
      int k;
      do_reset(); clear_obs();
      req1 = 1'b1; wr1 = 1'b0; sel1 = 4'b0100; addr1 = 7'h02; MRDATA = 32'hDEAD_BEEF;
      k = cyc + 1;
      run_obs(12, 0);
      checks++; if ((mt_cyc.size() > 0 ? {mt_wr[0], mt_sel[0], mt_addr[0]} : 12'hX) !== {1'b0, 4'b0100, 7'h02})
         begin errors++; $display("FAIL rd_mside_fields: got %h expected %h", (mt_cyc.size() > 0 ? {mt_wr[0], mt_sel[0], mt_addr[0]} : 12'hX), {1'b0, 4'b0100, 7'h02}); end
      checks++; if (ack_cyc.size() !== 1) begin errors++; $display("FAIL rd_ack_count: got %0d expected 1", ack_cyc.size()); end
      checks++; if ((ack_who.size() > 0 ? ack_who[0] : -1) !== 1) begin errors++; $display("FAIL rd_ack_owner: got %0d expected 1", (ack_who.size() > 0 ? ack_who[0] : -1)); end
      checks++; if ((ack_cyc.size() > 0 ? ack_cyc[0] : -1) !== k + int'(XFER) + 1) begin errors++; $display("FAIL rd_ack_cycle: got %0d expected %0d", (ack_cyc.size() > 0 ? ack_cyc[0] : -1), k + int'(XFER) + 1); end
      checks++; if (rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata1: got %h expected deadbeef", rdata1); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rd_rdata0_kept: got %h expected 0", rdata0); end
   endtask

   task automatic test_tie;
      int k;
      int nt;
      do_reset(); clear_obs();
      req0 = 1'b1; wr0 = 1'b1; sel0 = 4'b0001; addr0 = 7'h01; wdata0 = 20'h00111;
      req1 = 1'b1; wr1 = 1'b1; sel1 = 4'b0010; addr1 = 7'h02; wdata1 = 20'h00222;
      k = cyc + 1;
      run_obs(6 * (int'(XFER) + 3) + 2, 1);
      req0 = 1'b0; req1 = 1'b0;
      run_obs(12, 0);
      checks++; if (mt_cyc.size() < 6) begin errors++; $display("FAIL tie_transfer_count: got %0d expected at least 6", mt_cyc.size()); end
      nt = (mt_cyc.size() < 6) ? mt_cyc.size() : 6;
      if (ack_who.size() < nt) nt = ack_who.size();
      for (int j = 0; j < nt; j++) begin
         checks++; if (mt_cyc[j] !== k + j * (int'(XFER) + 3)) begin errors++; $display("FAIL tie_mtrans_cycle[%0d]: got %0d expected %0d", j, mt_cyc[j], k + j * (int'(XFER) + 3)); end
         checks++; if (ack_who[j] !== j % 2) begin errors++; $display("FAIL tie_owner[%0d]: got %0d expected %0d", j, ack_who[j], j % 2); end
         checks++; if (mt_addr[j] !== ((j % 2 == 0) ? 7'h01 : 7'h02)) begin errors++; $display("FAIL tie_addr[%0d]: got %h expected %h", j, mt_addr[j], ((j % 2 == 0) ? 7'h01 : 7'h02)); end
      end
   endtask

   task automatic test_null_sel;
      int k;
      do_reset(); clear_obs();
      req0 = 1'b1; wr0 = 1'b0; sel0 = 4'b1000; addr0 = 7'h03; MRDATA = 32'h1234_5678;
      run_obs(10, 0);
      clear_obs();
      req0 = 1'b1; wr0 = 1'b0; sel0 = 4'b0000; addr0 = 7'h44; MRDATA = 32'hAAAA_5555;
      k = cyc + 1;
      run_obs(10, 0);
      checks++; if (mt_cyc.size() !== 0) begin errors++; $display("FAIL null_mtrans_count: got %0d expected 0", mt_cyc.size()); end
      checks++; if (ack_cyc.size() !== 1) begin errors++; $display("FAIL null_ack_count: got %0d expected 1", ack_cyc.size()); end
      checks++; if ((ack_cyc.size() > 0 ? ack_cyc[0] : -1) !== k + 1) begin errors++; $display("FAIL null_ack_cycle: got %0d expected %0d", (ack_cyc.size() > 0 ? ack_cyc[0] : -1), k + 1); end
      checks++; if ((ack_who.size() > 0 ? ack_who[0] : -1) !== 0) begin errors++; $display("FAIL null_ack_owner: got %0d expected 0", (ack_who.size() > 0 ? ack_who[0] : -1)); end
      checks++; if (rdata0 !== 32'h1234_5678) begin errors++; $display("FAIL null_rdata0_kept: got %h expected 12345678", rdata0); end
      checks++; if ({MSELx, MADDR} !== {4'h0, 7'h03}) begin errors++; $display("FAIL null_mside_hold: got %h expected %h", {MSELx, MADDR}, {4'h0, 7'h03}); end
   endtask

   task automatic test_reset_mid_wait;
      int k;
      do_reset(); clear_obs();
      req0 = 1'b1; wr0 = 1'b0; sel0 = 4'b0010; addr0 = 7'h11; wdata0 = 20'h0ABCD; MRDATA = 32'hCAFE_F00D;
      k = cyc + 1;
      run_obs(3, 0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      run_obs(1, 0);
      checks++; if ({MTRANS, MWRITE, MSELx, MADDR, MWDATA} !== 33'h0) begin errors++; $display("FAIL rstw_mside_reset: got %h expected 0", {MTRANS, MWRITE, MSELx, MADDR, MWDATA}); end
      checks++; if ({ack0, ack1, busy} !== 3'b000) begin errors++; $display("FAIL rstw_ack_busy: got %b expected 000", {ack0, ack1, busy}); end
      checks++; if ({rdata0, rdata1} !== 64'h0) begin errors++; $display("FAIL rstw_rdata: got %h expected 0", {rdata0, rdata1}); end
      rst = 1'b0; req0 = 1'b0;
      run_obs(1, 0);
      req0 = 1'b1; wr0 = 1'b1; sel0 = 4'b0001; addr0 = 7'h22; wdata0 = 20'h54321;
      k = cyc + 1;
      run_obs(12, 0);
      checks++; if (mt_cyc.size() !== 2) begin errors++; $display("FAIL rstw_mtrans_count: got %0d expected 2", mt_cyc.size()); end
      checks++; if ((mt_cyc.size() > 1 ? mt_cyc[1] : -1) !== k) begin errors++; $display("FAIL rstw_new_mtrans: got %0d expected %0d", (mt_cyc.size() > 1 ? mt_cyc[1] : -1), k); end
      checks++; if (ack_cyc.size() !== 1) begin errors++; $display("FAIL rstw_ack_count: got %0d expected 1", ack_cyc.size()); end
      checks++; if ((ack_cyc.size() > 0 ? ack_cyc[0] : -1) !== k + int'(XFER) + 1) begin errors++; $display("FAIL rstw_ack_cycle: got %0d expected %0d", (ack_cyc.size() > 0 ? ack_cyc[0] : -1), k + int'(XFER) + 1); end
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rstw_rdata0: got %h expected 0", rdata0); end
   endtask

   task automatic test_drop_in_wait;
      int k;
      do_reset(); clear_obs();
      req0 = 1'b1; wr0 = 1'b1; sel0 = 4'b1000; addr0 = 7'h33; wdata0 = 20'h77777;
      k = cyc + 1;
      run_obs(2, 0);
      req0 = 1'b0;
      run_obs(14, 0);
      checks++; if (mt_cyc.size() !== 1) begin errors++; $display("FAIL drop_mtrans_count: got %0d expected 1", mt_cyc.size()); end
      checks++; if (ack_cyc.size() !== 1) begin errors++; $display("FAIL drop_ack_count: got %0d expected 1", ack_cyc.size()); end
      checks++; if ((ack_cyc.size() > 0 ? ack_cyc[0] : -1) !== k + int'(XFER) + 1) begin errors++; $display("FAIL drop_ack_cycle: got %0d expected %0d", (ack_cyc.size() > 0 ? ack_cyc[0] : -1), k + int'(XFER) + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_end: got %b expected 0", busy); end
   endtask

   // Timeline model: an idle arbiter takes the round-robin winner; a real transfer occupies
   // XFER+2 cycles and acks at +XFER+1, a null one acks at +1; the next grant is two cycles after ack.
   task automatic test_random;
      bit            e_mt[RL];
      bit            e_a0[RL];
      bit            e_a1[RL];
      bit            e_busy[RL];
      logic [NS-1:0] e_sel[RL];
      logic          e_wr[RL];
      logic [AW-1:0] e_addr[RL];
      logic [CW-1:0] e_dat[RL];
      logic [PW-1:0] mrd[RL];
      bit            pend[2];
      int            drop_at[2], idle_until[2], rd_at[2];
      logic          q_wr[2];
      logic [NS-1:0] q_sel[2];
      logic [AW-1:0] q_addr[2];
      logic [CW-1:0] q_dat[2];
      logic [PW-1:0] e_rd[2];
      logic          h_wr;
      logic [AW-1:0] h_addr;
      logic [CW-1:0] h_dat;
      int free_at, last, n, ack, win;
      for (int j = 0; j < RL; j++) begin
         e_mt[j] = 0; e_a0[j] = 0; e_a1[j] = 0; e_busy[j] = 0; e_sel[j] = '0;
         e_wr[j] = 1'b0; e_addr[j] = '0; e_dat[j] = '0; mrd[j] = '0;
      end
      for (int i = 0; i < 2; i++) begin
         pend[i] = 0; drop_at[i] = -1; idle_until[i] = 0; rd_at[i] = -1;
         q_wr[i] = 1'b0; q_sel[i] = '0; q_addr[i] = '0; q_dat[i] = '0; e_rd[i] = '0;
      end
      h_wr = 1'b0; h_addr = '0; h_dat = '0; free_at = 0; last = 1;
      do_reset();
      for (int t = 0; t < RN; t++) begin
         MRDATA = $urandom; mrd[t] = MRDATA;
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && t == drop_at[i]) begin
               pend[i] = 0; idle_until[i] = t + 1 + int'($urandom_range(0, 3));
            end else if (!pend[i] && t >= idle_until[i] && t < RN - 20 && $urandom_range(0, 2) == 0) begin
               pend[i] = 1; drop_at[i] = -1;
               q_wr[i] = 1'($urandom); q_addr[i] = 7'($urandom); q_dat[i] = 20'($urandom);
               case ($urandom_range(0, 4))
                  0:       q_sel[i] = '0;
                  1:       q_sel[i] = 4'($urandom);
                  default: q_sel[i] = 4'(1 << $urandom_range(0, 3));
               endcase
            end
         end
         req0 = pend[0]; wr0 = q_wr[0]; sel0 = q_sel[0]; addr0 = q_addr[0]; wdata0 = q_dat[0];
         req1 = pend[1]; wr1 = q_wr[1]; sel1 = q_sel[1]; addr1 = q_addr[1]; wdata1 = q_dat[1];
         n = t + 1;
         if (n >= free_at && (pend[0] || pend[1])) begin
            win = (pend[0] && pend[1]) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
            last = win;
            if (q_sel[win] != '0) begin
               e_mt[n] = 1; e_wr[n] = q_wr[win]; e_addr[n] = q_addr[win]; e_dat[n] = q_dat[win];
               for (int j = n; j <= n + int'(XFER); j++) e_sel[j] = q_sel[win];
               ack = n + int'(XFER) + 1;
               if (!q_wr[win]) rd_at[win] = ack;
            end else begin
               ack = n + 1;
            end
            if (win == 0) e_a0[ack] = 1; else e_a1[ack] = 1;
            for (int j = n; j <= ack; j++) e_busy[j] = 1;
            free_at = ack + 2; drop_at[win] = ack + 1;
         end
         @(negedge clk);
         if (e_mt[t]) begin h_wr = e_wr[t]; h_addr = e_addr[t]; h_dat = e_dat[t]; end
         for (int i = 0; i < 2; i++) if (rd_at[i] == t && t > 0) e_rd[i] = mrd[t-1];
         checks++; if (MTRANS !== e_mt[t]) begin errors++; $display("FAIL rnd_mtrans t=%0d: got %b expected %b", t, MTRANS, e_mt[t]); end
         checks++; if (ack0 !== e_a0[t]) begin errors++; $display("FAIL rnd_ack0 t=%0d: got %b expected %b", t, ack0, e_a0[t]); end
         checks++; if (ack1 !== e_a1[t]) begin errors++; $display("FAIL rnd_ack1 t=%0d: got %b expected %b", t, ack1, e_a1[t]); end
         checks++; if (busy !== e_busy[t]) begin errors++; $display("FAIL rnd_busy t=%0d: got %b expected %b", t, busy, e_busy[t]); end
         checks++; if (MSELx !== e_sel[t]) begin errors++; $display("FAIL rnd_msel t=%0d: got %h expected %h", t, MSELx, e_sel[t]); end
         checks++; if ({MWRITE, MADDR, MWDATA} !== {h_wr, h_addr, h_dat}) begin errors++; $display("FAIL rnd_mfields t=%0d: got %h expected %h", t, {MWRITE, MADDR, MWDATA}, {h_wr, h_addr, h_dat}); end
         checks++; if (rdata0 !== e_rd[0]) begin errors++; $display("FAIL rnd_rdata0 t=%0d: got %h expected %h", t, rdata0, e_rd[0]); end
         checks++; if (rdata1 !== e_rd[1]) begin errors++; $display("FAIL rnd_rdata1 t=%0d: got %h expected %h", t, rdata1, e_rd[1]); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_tie();
      test_null_sel();
      test_reset_mid_wait();
      test_drop_in_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfg_arbiter.md
CFG_ARBITER -- requirements
Module: cfg_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 7, APB register address width.
- COEFF_WIDTH, 20, write-data width.
- PDATA_WIDTH, 32, read-data width.
- COMP, 4, number of one-hot slave selects.
- XFER_CYCLES, 3, bridge cycles per transfer after the issue cycle.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req0 / req1, in, 1, transfer request from requester 0 (host) / requester 1 (reload sequencer).
- wr0 / wr1, in, 1, 1 = write, 0 = read.
- sel0 / sel1, in, COMP, one-hot slave select.
- addr0 / addr1, in, ADDR_WIDTH, register address.
- wdata0 / wdata1, in, COEFF_WIDTH (signed), write data.
- ack0 / ack1, out, 1, one-cycle completion pulse.
- rdata0 / rdata1, out, PDATA_WIDTH, read result.
- MTRANS, out, 1, one-cycle transfer start to the bridge.
- MWRITE, out, 1, write flag.
- MSELx, out, COMP, slave select.
- MADDR, out, ADDR_WIDTH, address.
- MWDATA, out, COEFF_WIDTH, write data.
- MRDATA, in, PDATA_WIDTH, bridge read data.
- busy, out, 1, high when the state is not IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-005 In IDLE, if req0 or req1 is high, the FSM SHALL latch the winning requester's wr/sel/addr/wdata and the grant ID, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin:
- single request: that requester wins;
- both requesting: the requester not granted last wins;
- the last-grant pointer after reset = 1, so req0 wins the first tie.
REQ-007 ISSUE SHALL last exactly one cycle with MTRANS = 1, then go to WAIT with the wait counter cleared.
REQ-008 In ISSUE and every WAIT cycle, MWRITE/MSELx/MADDR/MWDATA SHALL be driven from the latched values.
REQ-009 In IDLE and DONE, MSELx SHALL be 0, MTRANS SHALL be 0, and MWRITE/MADDR/MWDATA SHALL hold their last values.
REQ-010 WAIT SHALL last exactly XFER_CYCLES cycles, counted by a counter of width clog2(XFER_CYCLES+1); on the last WAIT cycle the FSM SHALL go to DONE.
REQ-011 On the WAIT→DONE transition, for a read (latched wr = 0), rdataN of the granted requester SHALL load MRDATA; for a write, rdataN SHALL be unchanged.
REQ-012 DONE SHALL last one cycle with ackN = 1 for the granted requester only, then return to IDLE unconditionally.
REQ-013 Latency SHALL be: request sampled in IDLE at edge k → MTRANS high in cycle k+1 → ack high in cycle k+2+XFER_CYCLES (cycle k+5 at default).
REQ-014 The minimum spacing between MTRANS pulses SHALL be XFER_CYCLES+3 cycles.
REQ-015 A requester SHALL hold its fields stable while req is high, and SHALL drop req in the cycle after ack.
REQ-016 req inputs SHALL be ignored in ISSUE, WAIT and DONE, so the losing requester stays pending with no lost or duplicated request.
REQ-017 If req drops mid-transfer, the transfer SHALL still complete and ack SHALL still pulse.
REQ-018 If the winner's sel is all zeros (null transfer), the FSM SHALL go IDLE → DONE directly with no MTRANS and rdataN unchanged, and ack SHALL pulse 2 cycles after the request is sampled.
REQ-019 A sel with more than one bit set SHALL be forwarded unmodified (legality is the requester's responsibility).
REQ-020 The busy output SHALL be a registered output equal to (state != IDLE).

Reset
REQ-021 While rst = 1 at a clk edge, the block SHALL set:
- state = IDLE;
- MTRANS, MWRITE, MSELx, MADDR, MWDATA = 0;
- ack0, ack1 = 0; rdata0, rdata1 = 0;
- busy = 0; wait counter = 0; last-grant pointer = 1.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no ack, and the FSM SHALL resume in IDLE on the first cycle after rst deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus → required response):
- Single write: req0 with wr=1, sel=4'b0001, addr=7'h05, wdata=20'h12345 → MTRANS in cycle k+1 with those values on the M-side, ack0 in cycle k+5, rdata0 unchanged.
- Read: req1 with wr=0, sel=4'b0100, addr=7'h02 and bridge MRDATA=32'hDEAD_BEEF → rdata1=32'hDEADBEEF with ack1 in cycle k+5, ack0 never high.
- Tie after reset: req0 and req1 both high → req0 served first, req1 served next with MTRANS spacing of 6 cycles; a second simultaneous tie then favours the other requester in strict alternation over 6 transfers.
- Null select: req0 with sel=0 → no MTRANS, ack0 in cycle k+2.
- Reset mid-WAIT: rst=1 on the 2nd WAIT cycle → no ack, all outputs at reset values, and a new req0 one cycle after rst deasserts is served normally.
- Requester drops req in WAIT → ack still pulses in cycle k+5 and no second MTRANS follows.
